axi_lite_decoder_n: RTL

AXI_LITE_DECODER_N -- requirements
Module: axi_lite_decoder_n

---
 rtl/axi_lite_decoder_n.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_decoder_n.sv
// AXI4-Lite 1:N address decoder with independent single-outstanding write and read engines.
// The upstream request is registered, decoded against the window table, and forwarded to one downstream port.
module axi_lite_decoder_n #(
    parameter int                          NUM_MASTERS = 2,
    parameter logic [NUM_MASTERS*32-1:0]   BASE_ADDR   = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_MASTERS*32-1:0]   ADDR_MASK   = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter bit                          STRIP_BASE  = 1'b0
) (
    input  logic                       axi_aclk,
    input  logic                       axi_areset,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [31:0]                s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    output logic [1:0]                 s_axi_bresp,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    input  logic [31:0]                s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic [NUM_MASTERS-1:0]     m_axi_awvalid,
    input  logic [NUM_MASTERS-1:0]     m_axi_awready,
    output logic [NUM_MASTERS*32-1:0]  m_axi_awaddr,
    output logic [NUM_MASTERS*3-1:0]   m_axi_awprot,
    output logic [NUM_MASTERS-1:0]     m_axi_wvalid,
    input  logic [NUM_MASTERS-1:0]     m_axi_wready,
    output logic [NUM_MASTERS*32-1:0]  m_axi_wdata,
    output logic [NUM_MASTERS*4-1:0]   m_axi_wstrb,
    input  logic [NUM_MASTERS-1:0]     m_axi_bvalid,
    output logic [NUM_MASTERS-1:0]     m_axi_bready,
    input  logic [NUM_MASTERS*2-1:0]   m_axi_bresp,
    output logic [NUM_MASTERS-1:0]     m_axi_arvalid,
    input  logic [NUM_MASTERS-1:0]     m_axi_arready,
    output logic [NUM_MASTERS*32-1:0]  m_axi_araddr,
    output logic [NUM_MASTERS*3-1:0]   m_axi_arprot,
    input  logic [NUM_MASTERS-1:0]     m_axi_rvalid,
    output logic [NUM_MASTERS-1:0]     m_axi_rready,
    input  logic [NUM_MASTERS*32-1:0]  m_axi_rdata,
    input  logic [NUM_MASTERS*2-1:0]   m_axi_rresp
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {W_IDLE, W_CAPTURE, W_FWD, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_RESP} rstate_t;

    // Returns {hit, index}; scanning downwards lets the lowest matching window win.
    function automatic logic [IDX_W:0] decode(input logic [31:0] addr);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASK[i*32 +: 32]) == BASE_ADDR[i*32 +: 32])
                res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    wstate_t          w_state;
    rstate_t          r_state;
    logic             aw_got, w_got, w_hit;
    logic [IDX_W-1:0] w_sel, r_sel;
    logic [31:0]      aw_addr, ar_addr, w_data;
    logic [2:0]       aw_prot, ar_prot;
    logic [3:0]       w_strb;
    logic             awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic [IDX_W:0]   aw_dec, ar_dec;
    logic             aw_hs, w_hs, ar_hs, aw_hit_now;

    assign aw_dec = decode(s_axi_awaddr);
    assign ar_dec = decode(s_axi_araddr);

    assign s_axi_awready = !axi_areset && (w_state == W_IDLE || w_state == W_CAPTURE) && !aw_got;
    assign s_axi_wready  = !axi_areset && (w_state == W_IDLE || w_state == W_CAPTURE) && !w_got;
    assign s_axi_arready = !axi_areset && (r_state == R_IDLE);

    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign ar_hs      = s_axi_arvalid && s_axi_arready;
    assign aw_hit_now = aw_got ? w_hit : aw_dec[IDX_W];

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            w_state      <= W_IDLE;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            w_hit        <= 1'b0;
            w_sel        <= '0;
            aw_addr      <= '0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE, W_CAPTURE: begin
                    if (aw_hs) begin
                        aw_got  <= 1'b1;
                        aw_addr <= s_axi_awaddr;
                        w_hit   <= aw_dec[IDX_W];
                        w_sel   <= aw_dec[IDX_W-1:0];
                    end
                    if (w_hs)
                        w_got <= 1'b1;
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        if (aw_hit_now) begin
                            w_state   <= W_FWD;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end else begin
                            // Unmapped: answer DECERR locally, nothing goes downstream.
                            w_state      <= W_RESP;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= 2'b11;
                        end
                    end else if (aw_hs || w_hs) begin
                        w_state <= W_CAPTURE;
                    end
                end
                W_FWD: begin
                    if (m_axi_awready[w_sel])
                        awvalid_r <= 1'b0;
                    if (m_axi_wready[w_sel])
                        wvalid_r <= 1'b0;
                    if ((!awvalid_r || m_axi_awready[w_sel]) && (!wvalid_r || m_axi_wready[w_sel])) begin
                        w_state  <= W_WAIT;
                        bready_r <= 1'b1;
                    end
                end
                W_WAIT: begin
                    if (m_axi_bvalid[w_sel]) begin
                        w_state      <= W_RESP;
                        bready_r     <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= m_axi_bresp[w_sel*2 +: 2];
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state      <= W_IDLE;
                        s_axi_bvalid <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state      <= R_IDLE;
            r_sel        <= '0;
            ar_addr      <= '0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr <= s_axi_araddr;
                        r_sel   <= ar_dec[IDX_W-1:0];
                        if (ar_dec[IDX_W]) begin
                            r_state   <= R_FWD;
                            arvalid_r <= 1'b1;
                        end else begin
                            r_state      <= R_RESP;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rresp  <= 2'b11;
                            s_axi_rdata  <= '0;
                        end
                    end
                end
                R_FWD: begin
                    if (m_axi_arready[r_sel]) begin
                        r_state   <= R_WAIT;
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (m_axi_rvalid[r_sel]) begin
                        r_state      <= R_RESP;
                        rready_r     <= 1'b0;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rresp  <= m_axi_rresp[r_sel*2 +: 2];
                        s_axi_rdata  <= m_axi_rdata[r_sel*32 +: 32];
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_state      <= R_IDLE;
                        s_axi_rvalid <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Payload fields are qualified by the valids, so they carry no reset.
    always_ff @(posedge axi_aclk) begin
        if (aw_hs)
            aw_prot <= s_axi_awprot;
        if (w_hs) begin
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
        end
        if (ar_hs)
            ar_prot <= s_axi_arprot;
    end

    assign m_axi_awprot = {NUM_MASTERS{aw_prot}};
    assign m_axi_wdata  = {NUM_MASTERS{w_data}};
    assign m_axi_wstrb  = {NUM_MASTERS{w_strb}};
    assign m_axi_arprot = {NUM_MASTERS{ar_prot}};

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
        assign m_axi_awvalid[i] = awvalid_r && (w_sel == IDX_W'(i));
        assign m_axi_wvalid[i]  = wvalid_r  && (w_sel == IDX_W'(i));
        assign m_axi_bready[i]  = bready_r  && (w_sel == IDX_W'(i));
        assign m_axi_arvalid[i] = arvalid_r && (r_sel == IDX_W'(i));
        assign m_axi_rready[i]  = rready_r  && (r_sel == IDX_W'(i));
        assign m_axi_awaddr[i*32 +: 32] = STRIP_BASE ? (aw_addr & ~ADDR_MASK[i*32 +: 32]) : aw_addr;
        assign m_axi_araddr[i*32 +: 32] = STRIP_BASE ? (ar_addr & ~ADDR_MASK[i*32 +: 32]) : ar_addr;
    end

endmodule
